// File: rtl/sample_issuer.sv
// Batch sequencer: pulls a programmed number of samples from an upstream
// valid/ready source and issues them one at a time through a registered output stage.
module sample_issuer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  batch_len,
    input  logic              clear,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  remaining,
    output logic              busy,
    output logic              batch_done,
    output logic              err
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_to_issue;
    logic [CNT_W-1:0]  w_to_issue_nxt;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  w_remaining_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic              r_batch_done;
    logic              w_batch_done_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_src_hs;
    logic              w_out_hs;

    assign src_ready  = (r_state == ISSUE) && (r_to_issue != '0) && (!r_out_valid || out_ready);
    assign w_src_hs   = src_valid && src_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign remaining  = r_remaining;
    assign busy       = (r_state == ISSUE);
    assign batch_done = r_batch_done;
    assign err        = r_err;

    always_comb begin
        w_state_nxt      = r_state;
        w_to_issue_nxt   = r_to_issue;
        w_remaining_nxt  = r_remaining;
        w_out_data_nxt   = r_out_data;
        w_out_valid_nxt  = r_out_valid;
        w_batch_done_nxt = 1'b0;
        w_err_nxt        = 1'b0;

        if (clear) begin
            // Abort keeps out_data; only the batch bookkeeping is dropped.
            w_state_nxt     = IDLE;
            w_to_issue_nxt  = '0;
            w_remaining_nxt = '0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (batch_len != '0) begin
                            w_state_nxt     = ISSUE;
                            w_to_issue_nxt  = batch_len;
                            w_remaining_nxt = batch_len;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (w_src_hs) begin
                        w_out_data_nxt  = src_data;
                        w_out_valid_nxt = 1'b1;
                        w_to_issue_nxt  = r_to_issue - CNT_W'(1);
                    end else if (w_out_hs) begin
                        w_out_valid_nxt = 1'b0;
                    end
                    if (w_out_hs && (r_remaining != '0)) begin
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            w_state_nxt      = IDLE;
                            w_out_valid_nxt  = 1'b0;
                            w_batch_done_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_to_issue   <= '0;
            r_remaining  <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_batch_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_to_issue   <= w_to_issue_nxt;
            r_remaining  <= w_remaining_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_batch_done <= w_batch_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_sample_issuer.sv
// Self-checking bench for sample_issuer: directed scenarios plus random traffic,
// compared against a batch-level model (pulled/accepted counts and a pending-sample queue).
module tb_sample_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  batch_len = '0;
    logic        clear = 1'b0;
    logic [15:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  remaining;
    logic        busy;
    logic        batch_done;
    logic        err;

    sample_issuer #(.DATA_W(16), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .batch_len(batch_len), .clear(clear),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .remaining(remaining), .busy(busy), .batch_done(batch_done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Batch-level reference model
    bit          m_active;
    int          m_len, m_pulled, m_accepted;
    logic [15:0] m_q[$];
    logic [15:0] m_last_data;
    bit          m_done, m_err;
    logic        exp_sr, obs_sr;
    int          n_hs;

    function automatic logic [29:0] pack_obs();
        return {busy, batch_done, err, out_valid, remaining, out_data};
    endfunction

    function automatic logic [29:0] pack_exp();
        logic [9:0] rem;
        rem = m_active ? 10'(m_len - m_accepted) : 10'd0;
        return {m_active, m_done, m_err, (m_q.size() != 0), rem, m_last_data};
    endfunction

    task automatic model_update();
        bit out_hs;
        if (rst) begin
            m_active = 0; m_len = 0; m_pulled = 0; m_accepted = 0;
            m_q.delete(); m_last_data = '0; m_done = 0; m_err = 0;
            return;
        end
        m_done = 0; m_err = 0;
        if (clear) begin
            m_active = 0; m_len = 0; m_pulled = 0; m_accepted = 0; m_q.delete();
        end else if (!m_active) begin
            if (start) begin
                if (batch_len != 0) begin
                    m_active = 1; m_len = int'(batch_len); m_pulled = 0; m_accepted = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            out_hs = (m_q.size() != 0) && out_ready;
            if (out_hs) begin
                void'(m_q.pop_front());
                m_accepted++;
            end
            if (exp_sr && src_valid) begin
                m_q.push_back(src_data);
                m_pulled++;
                m_last_data = src_data;
            end
            if (m_accepted == m_len) begin
                m_active = 0;
                m_done = 1;
            end
        end
    endtask

    // Inputs are set at the falling edge; this advances one full cycle.
    task automatic step();
        #1;
        obs_sr = src_ready;
        exp_sr = m_active && (m_pulled < m_len) && ((m_q.size() == 0) || out_ready);
        if (src_valid && src_ready) n_hs++;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++;
        if (pack_obs() !== 30'd0) $display("FAIL reset_outputs got %h want %h", pack_obs(), 30'd0);
        else passes++;
        checks++;
        if (obs_sr !== 1'b0) $display("FAIL reset_src_ready got %b want 0", obs_sr);
        else passes++;
    endtask

    task automatic test_basic();
        logic [15:0] vals [4];
        int vcnt, dcnt;
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033; vals[3] = 16'h0044;
        start = 1'b1; batch_len = 10'd4;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || remaining !== 10'd4) $display("FAIL basic_load busy=%b rem=%0d want 1/4", busy, remaining);
        else passes++;
        n_hs = 0; vcnt = 0; dcnt = 0;
        src_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            src_data = vals[(n_hs < 4) ? n_hs : 3];
            step();
            checks++;
            if (obs_sr !== exp_sr) $display("FAIL basic_src_ready cyc %0d got %b want %b", c, obs_sr, exp_sr);
            else passes++;
            checks++;
            if (pack_obs() !== pack_exp()) $display("FAIL basic_outputs cyc %0d got %h want %h", c, pack_obs(), pack_exp());
            else passes++;
            if (out_valid === 1'b1) begin
                checks++;
                if (vcnt > 3 || out_data !== vals[vcnt]) $display("FAIL basic_data idx %0d got %h want %h", vcnt, out_data, vals[vcnt & 3]);
                else passes++;
                vcnt++;
            end
            if (batch_done === 1'b1) begin
                dcnt++;
                checks++;
                if (busy !== 1'b0 || remaining !== 10'd0) $display("FAIL basic_done_busy busy=%b rem=%0d want 0/0", busy, remaining);
                else passes++;
            end
        end
        src_valid = 1'b0;
        checks++;
        if (n_hs !== 4 || dcnt !== 1) $display("FAIL basic_counts hs=%0d done=%0d want 4/1", n_hs, dcnt);
        else passes++;
    endtask

    task automatic test_stall();
        logic [15:0] first;
        start = 1'b1; batch_len = 10'd3;
        step();
        start = 1'b0;
        src_valid = 1'b1; out_ready = 1'b1; src_data = 16'hA5A1;
        first = src_data;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== first) $display("FAIL stall_first got v=%b d=%h want 1/%h", out_valid, out_data, first);
        else passes++;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            src_data = 16'hA5A2 + 16'(c);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== first || obs_sr !== 1'b0)
                $display("FAIL stall_hold cyc %0d got v=%b d=%h sr=%b want 1/%h/0", c, out_valid, out_data, obs_sr, first);
            else passes++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            src_data = 16'hB000 + 16'(c);
            step();
            checks++;
            if (pack_obs() !== pack_exp() || obs_sr !== exp_sr) $display("FAIL stall_release cyc %0d got %h want %h", c, pack_obs(), pack_exp());
            else passes++;
        end
        src_valid = 1'b0;
        checks++;
        if (remaining !== 10'd0 || busy !== 1'b0) $display("FAIL stall_end rem=%0d busy=%b want 0/0", remaining, busy);
        else passes++;
    endtask

    task automatic test_zero_len();
        start = 1'b1; batch_len = 10'd0;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || remaining !== 10'd0 || out_valid !== 1'b0)
            $display("FAIL zero_len_err got err=%b busy=%b rem=%0d v=%b want 1/0/0/0", err, busy, remaining, out_valid);
        else passes++;
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) $display("FAIL zero_len_pulse got err=%b busy=%b want 0/0", err, busy);
        else passes++;
    endtask

    task automatic test_clear_max();
        logic [15:0] held;
        int guard;
        start = 1'b1; batch_len = 10'd1023;
        step();
        start = 1'b0;
        src_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (m_accepted < 10 && guard < 40) begin
            src_data = 16'($urandom);
            step();
            guard++;
        end
        checks++;
        if (remaining !== 10'd1013) $display("FAIL clear_pre_rem got %0d want 1013", remaining);
        else passes++;
        held = out_data;
        clear = 1'b1; start = 1'b1; batch_len = 10'd5;
        step();
        clear = 1'b0;
        checks++;
        if (remaining !== 10'd0 || busy !== 1'b0 || out_valid !== 1'b0 || batch_done !== 1'b0 || err !== 1'b0 || out_data !== held)
            $display("FAIL clear_abort got %h want rem/busy/v/done/err=0 data=%h", pack_obs(), held);
        else passes++;
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) $display("FAIL clear_start_ignored got busy=%b want 0", busy);
        else passes++;
        start = 1'b1; batch_len = 10'd2;
        step();
        start = 1'b0;
        n_hs = 0;
        for (int c = 0; c < 6; c++) begin
            src_data = 16'($urandom);
            step();
            checks++;
            if (pack_obs() !== pack_exp()) $display("FAIL clear_next_batch cyc %0d got %h want %h", c, pack_obs(), pack_exp());
            else passes++;
        end
        src_valid = 1'b0;
        checks++;
        if (n_hs !== 2) $display("FAIL clear_next_hs got %0d want 2", n_hs);
        else passes++;
    endtask

    task automatic test_start_midbatch();
        int guard;
        start = 1'b1; batch_len = 10'd5;
        step();
        start = 1'b0;
        src_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (m_accepted < 2 && guard < 20) begin
            src_data = 16'($urandom);
            step();
            guard++;
        end
        start = 1'b1; batch_len = 10'd7;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || remaining !== 10'd2) $display("FAIL mid_start_ignored got err=%b rem=%0d want 0/2", err, remaining);
        else passes++;
        guard = 0;
        while (batch_done !== 1'b1 && guard < 20) begin
            src_data = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
            guard++;
            checks++;
            if (pack_obs() !== pack_exp()) $display("FAIL mid_run cyc %0d got %h want %h", guard, pack_obs(), pack_exp());
            else passes++;
        end
        checks++;
        if (batch_done !== 1'b1) $display("FAIL mid_done_timeout got 0 want 1");
        else passes++;
        src_valid = 1'b0;
        start = 1'b1; batch_len = 10'd7;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || remaining !== 10'd7 || err !== 1'b0) $display("FAIL done_cycle_start got busy=%b rem=%0d err=%b want 1/7/0", busy, remaining, err);
        else passes++;
    endtask

    task automatic test_rst_midbatch();
        src_valid = 1'b1; out_ready = 1'b0; src_data = 16'hBEEF;
        step();
        checks++;
        if (out_valid !== 1'b1) $display("FAIL rst_mid_pre got v=%b want 1", out_valid);
        else passes++;
        rst = 1'b1;
        step();
        rst = 1'b0; src_valid = 1'b0;
        checks++;
        if (pack_obs() !== 30'd0) $display("FAIL rst_mid_outputs got %h want 0", pack_obs());
        else passes++;
        start = 1'b1; batch_len = 10'd1;
        step();
        start = 1'b0; src_valid = 1'b1; out_ready = 1'b1; src_data = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (pack_obs() !== pack_exp()) $display("FAIL rst_mid_fresh cyc %0d got %h want %h", c, pack_obs(), pack_exp());
            else passes++;
        end
        src_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            clear     = ($urandom_range(0, 99) < 3);
            start     = ($urandom_range(0, 99) < 15);
            batch_len = 10'($urandom_range(0, 12));
            src_valid = ($urandom_range(0, 99) < 70);
            src_data  = 16'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            step();
            checks++;
            if (obs_sr !== exp_sr) $display("FAIL rand_src_ready cyc %0d got %b want %b", c, obs_sr, exp_sr);
            else passes++;
            checks++;
            if (pack_obs() !== pack_exp()) $display("FAIL rand_outputs cyc %0d got %h want %h", c, pack_obs(), pack_exp());
            else passes++;
        end
        rst = 1'b0; clear = 1'b0; start = 1'b0; src_valid = 1'b0;
    endtask

    initial begin
        m_active = 0; m_len = 0; m_pulled = 0; m_accepted = 0;
        m_last_data = '0; m_done = 0; m_err = 0; n_hs = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_clear_max();
        test_start_midbatch();
        test_rst_midbatch();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sample_issuer.md
Name: sample_issuer

Overview:
- Transmit-side batch sequencer for the FIR accelerator datapath.
- Loads a batch length, pulls samples from an upstream valid/ready source, and presents them one at a time to the filter input through a registered valid/ready stage.
- Counts accepted samples down to zero, then pulses batch_done. It is the issuing end of the sample stream whose processed samples the accelerator's completion counter tallies.

Parameters:
- DATA_W, 16: sample width in bits.
- CNT_W, 10: batch counter width; maximum batch length is 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a batch; sampled only in IDLE.
- batch_len  input  CNT_W  samples in the batch; captured on start.
- clear  input  1  synchronous abort of the current batch.
- src_data  input  DATA_W  upstream sample.
- src_valid  input  1  upstream sample valid.
- src_ready  output  1  issuer accepts src_data this cycle.
- out_data  output  DATA_W  sample to the FIR input.
- out_valid  output  1  out_data valid.
- out_ready  input  1  FIR input accepts out_data.
- remaining  output  CNT_W  samples not yet accepted downstream.
- busy  output  1  batch in progress.
- batch_done  output  1  one-cycle pulse when the last sample is accepted.
- err  output  1  one-cycle pulse on start with batch_len==0.

Behaviour:
- Reset: sync, active-high, highest priority. State is IDLE and to_issue is 0. All outputs are 0: src_ready, out_data, out_valid, remaining, busy, batch_done, err.
- Internal counters:
  - to_issue (CNT_W): samples not yet pulled from the source.
  - remaining (CNT_W): samples not yet accepted downstream.
  - Both are unsigned and never wrap. Decrement is legal only when the counter is nonzero.
- States: IDLE, ISSUE.
- IDLE, start=1, batch_len!=0: next cycle to_issue=remaining=batch_len, busy=1, state ISSUE.
- IDLE, start=1, batch_len==0: err=1 for exactly one cycle; stay IDLE; counters unchanged.
- start while in ISSUE is ignored; it does not reload and does not raise err.
- src_ready is combinational: (state==ISSUE) && (to_issue!=0) && (!out_valid || out_ready).
- Source handshake (src_valid && src_ready):
  - out_data <= src_data, out_valid <= 1, to_issue decrements.
  - Latency is one cycle from source handshake to out_valid.
  - Throughput is one sample per cycle when out_ready is held high.
- Downstream handshake (out_valid && out_ready):
  - remaining decrements.
  - If no source handshake in the same cycle, out_valid <= 0.
  - Simultaneous source and downstream handshakes keep out_valid=1 with the new data.
- Stall: while out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Completion: a downstream handshake with remaining==1 gives, next cycle:
  - remaining=0, busy=0, out_valid=0, state IDLE;
  - batch_done=1 for exactly one cycle.
  A start in the cycle batch_done is high is accepted normally.
- clear=1 (below rst, above everything else), next cycle:
  - state IDLE, to_issue=0, remaining=0, busy=0, out_valid=0;
  - no batch_done and no err;
  - start in the same cycle as clear is ignored;
  - out_data retains its last value.
- rst asserted mid-batch behaves as clear and also zeroes out_data.
- src_ready is 0 in IDLE, regardless of src_valid.
- out_data changes only on a source handshake, clear excepted.
- Implementation: a single registered FSM with the two counters. No combinational path from out_ready to out_valid.

Test Plan:
- rst, then start with batch_len=4. Feed source data 0x0011, 0x0022, 0x0033, 0x0044, with src_valid and out_ready held at 1.
  -> out_data shows those values on consecutive cycles, each one cycle after its source handshake.
  -> remaining counts 4,3,2,1,0.
  -> batch_done pulses once with busy falling in the same cycle; exactly 4 src_ready handshakes.
- batch_len=3 with out_ready low for 5 cycles after the first sample.
  -> out_data=first sample held stable with out_valid=1 and src_ready=0 throughout the stall.
  -> Completes normally when released; remaining reaches 0.
- start with batch_len=0.
  -> err=1 for one cycle; busy, remaining and out_valid stay 0; state remains IDLE.
- batch_len=1023 (max), then assert clear after 10 accepted samples.
  -> remaining=1013 before clear.
  -> Next cycle remaining=0, busy=0, out_valid=0; no batch_done.
  -> A subsequent start with batch_len=2 completes with exactly 2 samples.
- start pulsed mid-batch with batch_len=7.
  -> Ignored: remaining continues from the current value, no err.
  -> A start in the batch_done cycle loads the new batch.
- rst asserted mid-batch with out_valid=1.
  -> Next cycle all outputs are 0 including out_data; the FSM accepts a fresh start.
